// File: rtl/mul_share_ctrl_pkg.sv
// mul_share_pkg: shared state encoding and default sizing for the multiplier-sharing controller
package mul_share_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_WD_W = $clog2(DEF_TIMEOUT + 1);
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: requester handshake and multiplier drive bundle; slave is the controller side
interface mul_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = mul_share_pkg::DEF_WIDTH
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*WIDTH-1:0] req_multiplier;
  logic [N_REQ*WIDTH-1:0] req_multiplicand;
  logic [N_REQ-1:0] resp_valid;
  logic [N_REQ-1:0] resp_ready;
  logic [2*WIDTH-1:0] resp_result;
  logic resp_error;
  logic mul_op_start;
  logic mul_op_clear;
  logic [WIDTH-1:0] mul_multiplier;
  logic [WIDTH-1:0] mul_multiplicand;
  logic mul_op_done;
  logic [2*WIDTH-1:0] mul_result;
  modport slave (
    input req_valid, req_multiplier, req_multiplicand, resp_ready, mul_op_done, mul_result,
    output req_ready, resp_valid, resp_result, resp_error,
    output mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand
  );
  modport master (
    output req_valid, req_multiplier, req_multiplicand, resp_ready, mul_op_done, mul_result,
    input req_ready, resp_valid, resp_result, resp_error,
    input mul_op_start, mul_op_clear, mul_multiplier, mul_multiplicand
  );
endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // scanning downward lets the slot nearest ptr overwrite farther ones
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant = N'(1) << j;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one multiplier among N_REQ requesters with a RUN watchdog
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic reset,
  mul_share_ctrl_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int WD_W = wd_width(TIMEOUT);
  state_t state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [WD_W-1:0] wd;
  logic [N_REQ-1:0] win;
  logic [IW-1:0] win_idx;
  logic any;
  logic [WIDTH-1:0] a_slot [N_REQ];
  logic [WIDTH-1:0] b_slot [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign a_slot[i] = bus.req_multiplier[i*WIDTH +: WIDTH];
    assign b_slot[i] = bus.req_multiplicand[i*WIDTH +: WIDTH];
  end
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (bus.req_valid),
    .ptr  (ptr),
    .grant(win),
    .idx  (win_idx),
    .any  (any)
  );
  assign bus.req_ready = (state == IDLE) ? win : '0;
  assign bus.resp_valid = (state == RESP) ? N_REQ'(1) << gnt : '0;
  assign bus.mul_op_start = state == RUN;
  assign bus.mul_op_clear = state != RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      wd <= '0;
      bus.mul_multiplier <= '0;
      bus.mul_multiplicand <= '0;
      bus.resp_result <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          bus.mul_multiplier <= a_slot[win_idx];
          bus.mul_multiplicand <= b_slot[win_idx];
          gnt <= win_idx;
          ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
          wd <= '0;
          state <= RUN;
        end
        RUN: begin
          wd <= wd + 1'b1;
          if (bus.mul_op_done) begin
            bus.resp_result <= bus.mul_result;
            bus.resp_error <= 1'b0;
            state <= RESP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            bus.resp_result <= '0;
            bus.resp_error <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (bus.resp_ready[gnt]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed vectors with a response scoreboard and a latency-programmable signed multiplier stub
module tb_mul_share_ctrl;
  localparam int N = 4;
  localparam int W = 64;
  localparam int TO = 255;
  typedef struct {int idx; logic [127:0] res; logic err;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mul_share_ctrl_if #(.N_REQ(N), .WIDTH(W)) bus ();
  mul_share_ctrl #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int lat = 4;
  bit hang = 1'b0;
  int cnt = 0;
  always @(posedge clk) cnt <= bus.mul_op_clear ? 0 : cnt + 1;
  assign bus.mul_op_done = bus.mul_op_start && !hang && (cnt == lat - 1);
  assign bus.mul_result = $signed({{W{bus.mul_multiplier[W-1]}}, bus.mul_multiplier}) *
                          $signed({{W{bus.mul_multiplicand[W-1]}}, bus.mul_multiplicand});
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic [63:0] a, input logic [63:0] b);
    bus.req_multiplier[i*W +: W] = a;
    bus.req_multiplicand[i*W +: W] = b;
  endtask
  task automatic push(input int i, input logic [127:0] r, input logic e);
    exp_t x;
    x.idx = i;
    x.res = r;
    x.err = e;
    q.push_back(x);
  endtask
  task automatic wait_accept(output int idx);
    logic [N-1:0] acc;
    int t;
    acc = '0;
    idx = -1;
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (acc != 0) break;
      t++;
    end
    if (acc == 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no req_ready, expected an accept");
    end else begin
      for (int i = 0; i < N; i++) if (acc[i]) idx = i;
      @(posedge clk);
      #1 bus.req_valid = bus.req_valid & ~acc;
    end
  endtask
  task automatic wait_resp();
    int t;
    t = 0;
    while (bus.resp_valid == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (bus.resp_valid == 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no resp_valid, expected a response");
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.resp_valid != 0) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid %b, expected none", bus.resp_valid);
        end else if ((bus.resp_valid & bus.resp_ready) != 0) begin
          e = q.pop_front();
          check("resp_valid", 128'(bus.resp_valid), 128'(N'(1) << e.idx));
          check("resp_result", bus.resp_result, e.res);
          check("resp_error", 128'(bus.resp_error), 128'(e.err));
        end
      end
    end
  end
  initial begin : stim
    int g;
    int n;
    logic bad;
    bus.req_valid = '0;
    bus.resp_ready = '1;
    bus.req_multiplier = '0;
    bus.req_multiplicand = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_op_start", 128'(bus.mul_op_start), 128'(0));
    check("rst_op_clear", 128'(bus.mul_op_clear), 128'(1));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_result", bus.resp_result, 128'(0));
    check("rst_resp_error", 128'(bus.resp_error), 128'(0));
    check("rst_operands", {bus.mul_multiplier, bus.mul_multiplicand}, 128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    lat = 40;
    set_slot(0, 64'd5, 64'd192);
    push(0, 128'd960, 1'b0);
    bus.req_valid = 4'b0001;
    wait_accept(g);
    check("single_grant", 128'(g), 128'(0));
    n = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.resp_valid != 0) break;
      n += int'(bus.mul_op_start);
    end
    check("single_start_cycles", 128'(n), 128'(40));
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    lat = 3;
    for (int i = 0; i < N; i++) begin
      set_slot(i, 64'(i * 10), 64'(i * 10));
      push(i, 128'(i * i * 100), 1'b0);
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_accept(g);
      check($sformatf("rr1_order%0d", k), 128'(g), 128'(k));
    end
    drain();
    push(1, 128'd100, 1'b0);
    push(3, 128'd900, 1'b0);
    bus.req_valid = 4'b1010;
    wait_accept(g);
    check("rr2_first", 128'(g), 128'(1));
    wait_accept(g);
    check("rr2_second", 128'(g), 128'(3));
    drain();
    set_slot(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA000_0000_0000_0000);
    push(2, 128'h0000_0000_0000_0000_6000_0000_0000_0000, 1'b0);
    bus.req_valid = 4'b0100;
    wait_accept(g);
    drain();
    set_slot(0, 64'hF000_0000_0000_0000, 64'd1);
    push(0, 128'hFFFF_FFFF_FFFF_FFFF_F000_0000_0000_0000, 1'b0);
    bus.req_valid = 4'b0001;
    wait_accept(g);
    drain();
    lat = 5;
    bus.resp_ready = 4'b1101;
    set_slot(1, 64'd3, 64'd4);
    set_slot(3, 64'd2, 64'd2);
    push(1, 128'd12, 1'b0);
    push(3, 128'd4, 1'b0);
    bus.req_valid = 4'b1010;
    wait_accept(g);
    check("bp_first", 128'(g), 128'(1));
    wait_resp();
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid != 4'b0010 || bus.resp_result != 128'd12 || !bus.mul_op_clear || bus.req_ready != 0)
        bad = 1'b1;
    end
    check("bp_stable", 128'(bad), 128'(0));
    check("bp_pending_q", 128'(q.size()), 128'(2));
    @(posedge clk);
    #1 bus.resp_ready = 4'b1111;
    wait_accept(g);
    check("bp_second", 128'(g), 128'(3));
    drain();
    hang = 1'b1;
    push(0, 128'd0, 1'b1);
    bus.req_valid = 4'b0001;
    wait_accept(g);
    n = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.resp_valid != 0) break;
      n++;
    end
    check("timeout_cycles", 128'(n), 128'(TO));
    drain();
    hang = 1'b0;
    set_slot(2, 64'd7, 64'd6);
    push(2, 128'd42, 1'b0);
    bus.req_valid = 4'b0100;
    wait_accept(g);
    drain();
    lat = 40;
    set_slot(1, 64'd9, 64'd9);
    bus.req_valid = 4'b0010;
    wait_accept(g);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("mrst_op_start", 128'(bus.mul_op_start), 128'(0));
    check("mrst_op_clear", 128'(bus.mul_op_clear), 128'(1));
    check("mrst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("mrst_ptr_zero", 128'(bus.req_ready), 128'(4'b0001));
    #1 bus.req_valid = '0;
    repeat (60) @(posedge clk);
    check("mrst_no_resp_pending", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
